// File: rtl/uart_work_rx.sv
// UART receiver that packs bytes big-endian into 32-bit work words and flags complete units.
// Define UART_RX_PARITY_EN for 8E1 framing; a bad parity bit is handled like a bad stop bit.
module uart_work_rx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int WORDS        = 19,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        rxd,
    output logic [31:0] word_data,
    output logic [4:0]  word_addr,
    output logic        word_we,
    output logic        work_valid,
    output logic        frame_error,
    output logic        timeout,
    output logic        rx_busy
);
    localparam int TIMEOUT_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TIMER_MAX      = (TIMEOUT_CYCLES > CLKS_PER_BIT) ? TIMEOUT_CYCLES : CLKS_PER_BIT;
    localparam int TW             = $clog2(TIMER_MAX + 1);

    localparam logic [TW-1:0] HALF_LOAD  = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] BIT_LOAD   = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] IDLE_LIMIT = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [4:0]    LAST_WORD  = 5'(WORDS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_HIGH
    } state_t;

    state_t        state;
    logic          rx_meta;
    logic          rxs;
    logic [TW-1:0] timer;
    logic [2:0]    bit_idx;
    logic [7:0]    rx_byte;
    logic [31:0]   shift_word;
    logic [1:0]    byte_cnt;
    logic [4:0]    word_cnt;
    logic [31:0]   next_word;
    logic          frame_ok;

`ifdef UART_RX_PARITY_EN
    logic          parity_bad;
    assign frame_ok = rxs && !parity_bad;
`else
    assign frame_ok = rxs;
`endif

    assign next_word = {shift_word[23:0], rx_byte};

    // rxd is asynchronous; reset to idle-high so reset never looks like a start bit
    always_ff @(posedge clock) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rxd;
            rxs     <= rx_meta;
        end
    end

    // The bit timer doubles as the inter-byte idle counter while in IDLE
    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= IDLE;
            timer       <= '0;
            bit_idx     <= '0;
            rx_byte     <= '0;
            shift_word  <= '0;
            byte_cnt    <= '0;
            word_cnt    <= '0;
            word_data   <= '0;
            word_addr   <= '0;
            word_we     <= 1'b0;
            work_valid  <= 1'b0;
            frame_error <= 1'b0;
            timeout     <= 1'b0;
            rx_busy     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bad  <= 1'b0;
`endif
        end else begin
            word_we     <= 1'b0;
            work_valid  <= 1'b0;
            frame_error <= 1'b0;
            timeout     <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rxs) begin
                        state   <= START;
                        timer   <= HALF_LOAD;
                        rx_busy <= 1'b1;
                    end else if (byte_cnt != '0 || word_cnt != '0) begin
                        if (timer == IDLE_LIMIT) begin
                            timeout  <= 1'b1;
                            byte_cnt <= '0;
                            word_cnt <= '0;
                            timer    <= '0;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                end
                START: begin
                    if (timer == '0) begin
                        if (!rxs) begin
                            state   <= DATA;
                            timer   <= BIT_LOAD;
                            bit_idx <= '0;
                        end else begin
                            state   <= IDLE;
                            timer   <= '0;
                            rx_busy <= 1'b0;
                        end
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                DATA: begin
                    if (timer == '0) begin
                        rx_byte <= {rxs, rx_byte[7:1]};
                        timer   <= BIT_LOAD;
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (timer == '0) begin
                        parity_bad <= ^{rx_byte, rxs};
                        timer      <= BIT_LOAD;
                        state      <= STOP;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (timer == '0) begin
                        timer <= '0;
                        if (frame_ok) begin
                            state      <= IDLE;
                            rx_busy    <= 1'b0;
                            shift_word <= next_word;
                            if (byte_cnt == 2'd3) begin
                                word_we   <= 1'b1;
                                word_data <= next_word;
                                word_addr <= word_cnt;
                                byte_cnt  <= '0;
                                if (word_cnt == LAST_WORD) begin
                                    work_valid <= 1'b1;
                                    word_cnt   <= '0;
                                end else begin
                                    word_cnt <= word_cnt + 1'b1;
                                end
                            end else begin
                                byte_cnt <= byte_cnt + 1'b1;
                            end
                        end else begin
                            frame_error <= 1'b1;
                            byte_cnt    <= '0;
                            word_cnt    <= '0;
                            state       <= WAIT_HIGH;
                        end
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                WAIT_HIGH: begin
                    if (rxs) begin
                        state   <= IDLE;
                        timer   <= '0;
                        rx_busy <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    timer   <= '0;
                    rx_busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_work_rx.sv
// Directed self-checking bench for uart_work_rx with CLKS_PER_BIT=8, WORDS=2, TIMEOUT_BITS=4.
// Define UART_RX_PARITY_EN for both files to exercise the 8E1 build.
module tb_uart_work_rx;
    localparam int CPB = 8;
    localparam int NW  = 2;
    localparam int TOB = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        rxd   = 1'b0;
    logic [31:0] word_data;
    logic [4:0]  word_addr;
    logic        word_we;
    logic        work_valid;
    logic        frame_error;
    logic        timeout;
    logic        rx_busy;

    int vectors     = 0;
    int miscompares = 0;

    int we_cnt    = 0;
    int valid_cnt = 0;
    int ferr_cnt  = 0;
    int tout_cnt  = 0;
    int wide_cnt  = 0;
    int busy_cnt  = 0;
    logic prev_we    = 1'b0;
    logic prev_valid = 1'b0;
    logic prev_ferr  = 1'b0;
    logic prev_tout  = 1'b0;
    logic [37:0] wlog[$];

`ifdef UART_RX_PARITY_EN
    logic flip_parity = 1'b0;
`endif

    always #5 clock = ~clock;

    uart_work_rx #(
        .CLKS_PER_BIT(CPB),
        .WORDS(NW),
        .TIMEOUT_BITS(TOB)
    ) dut (
        .clock(clock),
        .reset(reset),
        .rxd(rxd),
        .word_data(word_data),
        .word_addr(word_addr),
        .word_we(word_we),
        .work_valid(work_valid),
        .frame_error(frame_error),
        .timeout(timeout),
        .rx_busy(rx_busy)
    );

    // Pulse monitor: logs every write strobe and flags any strobe wider than one cycle
    always @(negedge clock) begin
        if (word_we) begin
            we_cnt++;
            wlog.push_back({work_valid, word_addr, word_data});
        end
        if (work_valid)  valid_cnt++;
        if (frame_error) ferr_cnt++;
        if (timeout)     tout_cnt++;
        if (rx_busy)     busy_cnt++;
        if ((word_we && prev_we) || (work_valid && prev_valid) ||
            (frame_error && prev_ferr) || (timeout && prev_tout))
            wide_cnt++;
        prev_we    = word_we;
        prev_valid = work_valid;
        prev_ferr  = frame_error;
        prev_tout  = timeout;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] data, input logic stop_bit);
        rxd = 1'b0;
        repeat (CPB) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            rxd = data[i];
            repeat (CPB) @(negedge clock);
        end
`ifdef UART_RX_PARITY_EN
        rxd = (^data) ^ flip_parity;
        repeat (CPB) @(negedge clock);
`endif
        rxd = stop_bit;
        repeat (CPB) @(negedge clock);
        rxd = 1'b1;
    endtask

    task automatic sendWord(input logic [31:0] w);
        applyStimulus(w[31:24], 1'b1);
        applyStimulus(w[23:16], 1'b1);
        applyStimulus(w[15:8],  1'b1);
        applyStimulus(w[7:0],   1'b1);
        repeat (4) @(negedge clock);
    endtask

    task automatic checkEntry(input string tag, input int idx, input logic valid,
                              input logic [4:0] addr, input logic [31:0] data);
        if (wlog.size() > idx)
            checkOutput(tag, 64'(wlog[idx]), 64'({valid, addr, data}));
        else
            checkOutput(tag, 64'(wlog.size()), 64'(idx + 1));
    endtask

    initial begin
        int base;
        int t0;
        int f0;
        int b0;
        int p0;

        reset = 1'b0;
        rxd   = 1'b0;
        repeat (3) @(negedge clock);
        checkOutput("reset_word_data", 64'(word_data), 64'h0);
        checkOutput("reset_word_addr", 64'(word_addr), 64'h0);
        checkOutput("reset_flags", 64'({word_we, work_valid, frame_error, timeout, rx_busy}), 64'h0);

        rxd = 1'b1;
        @(negedge clock);
        reset = 1'b1;
        repeat (20) @(negedge clock);
        checkOutput("idle_busy", 64'(busy_cnt), 64'h0);

        // Full two-word unit
        base = wlog.size();
        sendWord(32'h12345678);
        sendWord(32'h9ABCDEF0);
        checkOutput("unit_writes", 64'(wlog.size() - base), 64'd2);
        checkEntry("unit_word0", base, 1'b0, 5'd0, 32'h12345678);
        checkEntry("unit_word1", base + 1, 1'b1, 5'd1, 32'h9ABCDEF0);
        checkOutput("unit_valid_cnt", 64'(valid_cnt), 64'd1);
        checkOutput("hold_word_data", 64'(word_data), 64'h9ABCDEF0);
        checkOutput("hold_word_addr", 64'(word_addr), 64'd1);
        checkOutput("hold_we_low", 64'(word_we), 64'h0);

        t0 = tout_cnt;
        repeat (60) @(negedge clock);
        checkOutput("empty_idle_no_timeout", 64'(tout_cnt - t0), 64'h0);

        // Two-cycle glitch must not start a frame
        b0 = busy_cnt;
        p0 = we_cnt + valid_cnt + ferr_cnt + tout_cnt;
        rxd = 1'b0;
        repeat (2) @(negedge clock);
        rxd = 1'b1;
        repeat (20) @(negedge clock);
        checkOutput("glitch_busy_seen", 64'(busy_cnt > b0), 64'd1);
        checkOutput("glitch_busy_low", 64'(rx_busy), 64'h0);
        checkOutput("glitch_no_pulse", 64'(we_cnt + valid_cnt + ferr_cnt + tout_cnt - p0), 64'h0);

        // Bad stop bit aborts the partial word
        base = wlog.size();
        f0 = ferr_cnt;
        t0 = tout_cnt;
        applyStimulus(8'h11, 1'b1);
        applyStimulus(8'h5A, 1'b0);
        repeat (3 * CPB) @(negedge clock);
        checkOutput("ferr_once", 64'(ferr_cnt - f0), 64'd1);
        sendWord(32'hAABBCCDD);
        checkOutput("ferr_writes", 64'(wlog.size() - base), 64'd1);
        checkEntry("ferr_resync_word", base, 1'b0, 5'd0, 32'hAABBCCDD);
        sendWord(32'h01020304);
        checkEntry("ferr_unit_done", base + 1, 1'b1, 5'd1, 32'h01020304);
        checkOutput("ferr_no_timeout", 64'(tout_cnt - t0), 64'h0);

        // Idle mid-unit discards partial bytes and then a partial unit
        base = wlog.size();
        t0 = tout_cnt;
        applyStimulus(8'hC3, 1'b1);
        applyStimulus(8'h3C, 1'b1);
        repeat (40) @(negedge clock);
        checkOutput("timeout_bytes", 64'(tout_cnt - t0), 64'd1);
        checkOutput("timeout_no_write", 64'(wlog.size() - base), 64'h0);
        sendWord(32'h0BADF00D);
        checkEntry("timeout_resync_word", base, 1'b0, 5'd0, 32'h0BADF00D);
        repeat (40) @(negedge clock);
        checkOutput("timeout_word", 64'(tout_cnt - t0), 64'd2);
        sendWord(32'hCAFEBABE);
        checkEntry("timeout_addr_reset", base + 1, 1'b0, 5'd0, 32'hCAFEBABE);
        sendWord(32'h55AA33CC);
        checkEntry("timeout_unit_done", base + 2, 1'b1, 5'd1, 32'h55AA33CC);

`ifdef UART_RX_PARITY_EN
        // Even parity: good parity accepted, bad parity aborts like a framing error
        base = wlog.size();
        f0 = ferr_cnt;
        flip_parity = 1'b0;
        applyStimulus(8'h03, 1'b1);
        repeat (4) @(negedge clock);
        checkOutput("parity_good", 64'(ferr_cnt - f0), 64'h0);
        flip_parity = 1'b1;
        applyStimulus(8'h03, 1'b1);
        repeat (4) @(negedge clock);
        flip_parity = 1'b0;
        checkOutput("parity_bad", 64'(ferr_cnt - f0), 64'd1);
        sendWord(32'h03112233);
        checkEntry("parity_resync_word", base, 1'b0, 5'd0, 32'h03112233);
        sendWord(32'h44556677);
        checkEntry("parity_unit_done", base + 1, 1'b1, 5'd1, 32'h44556677);
`endif

        checkOutput("strobe_width", 64'(wide_cnt), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed no completion, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
